alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready request handshake.
// Single-cycle ADD/ADDC/SUB/AND/OR/NEG, iterative 1-bit-per-cycle shifts
// and a WIDTH-cycle unsigned shift-and-add multiply. Result, flags and the
// persistent carry flag are all registered; out_valid pulses on completion.
// Optional build macro ALU_SEQ_CARRY_REG_EN: when defined, ADDC consumes the
// internal carry flag instead of the cin port.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops complete from here
// SHIFT | shifting work register one bit per cycle, cnt bits remaining
// MUL   | shift-and-add iterations, cnt iterations remaining
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             cout,
  output logic             zero,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SLL  = 4'd3;
  localparam logic [3:0] OP_SRA  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_NEG  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  // Shift amounts saturate at WIDTH; the full b is compared, not just its low bits.
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
  localparam logic [SHW-1:0]   W_CNT = SHW'(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_t;

  state_t           state;
  logic             carry_flag;
  logic [WIDTH-1:0] work;      // shift operand, or multiplier / low product in MUL
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [SHW-1:0]   cnt;
  logic [3:0]       sh_op;

  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_upd;
  logic [WIDTH:0]   sum_w;
  logic             is_shift;
  logic             is_mul;
  logic             c_src;
  logic [SHW-1:0]   k;
  logic [WIDTH-1:0] shift_nx;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_nx;
  logic [WIDTH-1:0] mul_lo_nx;

`ifdef ALU_SEQ_CARRY_REG_EN
  assign c_src = carry_flag;
  logic unused_cin;
  assign unused_cin = cin;
`else
  assign c_src = cin;
`endif

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  assign is_mul   = (op == OP_MUL);
  assign k        = (b >= W_LIM) ? W_CNT : b[SHW-1:0];

  // Single-cycle datapath; a zero-length shift passes a through unchanged.
  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_upd = 1'b0;
    sum_w   = '0;
    case (op)
      OP_ADD: begin
        sum_w   = {1'b0, a} + {1'b0, b};
        res     = sum_w[WIDTH-1:0];
        res_c   = sum_w[WIDTH];
        res_upd = 1'b1;
      end
      OP_ADDC: begin
        sum_w   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_src};
        res     = sum_w[WIDTH-1:0];
        res_c   = sum_w[WIDTH];
        res_upd = 1'b1;
      end
      OP_SUB: begin
        sum_w   = {1'b0, a} - {1'b0, b};
        res     = sum_w[WIDTH-1:0];
        res_c   = ~sum_w[WIDTH];
        res_upd = 1'b1;
      end
      OP_AND:                 res = a & b;
      OP_OR:                  res = a | b;
      OP_NEG:                 res = ~a;
      OP_SLL, OP_SRL, OP_SRA: res = a;
      default:                res = '0;
    endcase
  end

  // One-bit shift of the work register for the latched shift kind.
  always_comb begin
    case (sh_op)
      OP_SLL:  shift_nx = {work[WIDTH-2:0], 1'b0};
      OP_SRL:  shift_nx = {1'b0, work[WIDTH-1:1]};
      default: shift_nx = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  // One shift-and-add step: conditionally add the multiplicand, then shift {hi,lo} right.
  assign mul_sum   = {1'b0, acc_hi} + (work[0] ? {1'b0, mcand} : '0);
  assign mul_hi_nx = mul_sum[WIDTH:1];
  assign mul_lo_nx = {mul_sum[0], work[WIDTH-1:1]};

  // Control FSM with registered results, flags and carry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      carry_flag <= 1'b0;
      work       <= '0;
      mcand      <= '0;
      acc_hi     <= '0;
      cnt        <= '0;
      sh_op      <= '0;
      out        <= '0;
      out_hi     <= '0;
      cout       <= 1'b0;
      zero       <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (k != '0)) begin
              state <= SHIFT;
              work  <= a;
              cnt   <= k;
              sh_op <= op;
            end else if (is_mul) begin
              state  <= MUL;
              work   <= b;
              mcand  <= a;
              acc_hi <= '0;
              cnt    <= W_CNT;
            end else begin
              out       <= res;
              out_hi    <= '0;
              cout      <= res_c;
              zero      <= (res == '0);
              out_valid <= 1'b1;
              if (res_upd) carry_flag <= res_c;
            end
          end
        end
        SHIFT: begin
          work <= shift_nx;
          cnt  <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state     <= IDLE;
            out       <= shift_nx;
            out_hi    <= '0;
            cout      <= 1'b0;
            zero      <= (shift_nx == '0);
            out_valid <= 1'b1;
          end
        end
        MUL: begin
          work   <= mul_lo_nx;
          acc_hi <= mul_hi_nx;
          cnt    <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state     <= IDLE;
            out       <= mul_lo_nx;
            out_hi    <= mul_hi_nx;
            cout      <= |mul_hi_nx;
            zero      <= (mul_lo_nx == '0);
            out_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq against an
// arithmetic reference model (WIDTH=8).
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic [W-1:0] out;
  logic [W-1:0] out_hi;
  logic         cout;
  logic         zero;
  logic         busy;

  int   n_checks = 0;
  int   n_errors = 0;
  logic m_carry  = 1'b0;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out(out),
    .out_hi(out_hi), .cout(cout), .zero(zero), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: results from plain integer arithmetic on the opcode rules.
  function automatic void model(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                                input logic ci, input logic cf,
                                output logic [W-1:0] lo, output logic [W-1:0] hi, output logic c,
                                output int lat, output logic upd);
    int unsigned ua = aa;
    int unsigned ub = bb;
    int unsigned m  = 1 << W;
    int unsigned k;
    int unsigned r;
    int          s;
    logic        csrc;
`ifdef ALU_SEQ_CARRY_REG_EN
    csrc = cf;
`else
    csrc = ci;
`endif
    k = (ub > W) ? W : ub;
    lo = '0; hi = '0; c = 1'b0; lat = 1; upd = 1'b0;
    case (o)
      4'd0: begin r = ua + ub; lo = W'(r % m); c = (r >= m); upd = 1'b1; end
      4'd1: begin r = ua + ub + csrc; lo = W'(r % m); c = (r >= m); upd = 1'b1; end
      4'd2: begin lo = W'((ua + m - ub) % m); c = (ua >= ub); upd = 1'b1; end
      4'd3: begin lo = (k >= W) ? '0 : W'((ua << k) % m); lat = 1 + int'(k); end
      4'd4: begin
        s   = aa[W-1] ? int'(ua) - int'(m) : int'(ua);
        lo  = W'(s >>> k);
        lat = 1 + int'(k);
      end
      4'd5: lo = aa & bb;
      4'd6: lo = aa | bb;
      4'd7: lo = ~aa;
      4'd8: begin lo = W'(ua >> k); lat = 1 + int'(k); end
      4'd9: begin r = ua * ub; lo = W'(r % m); hi = W'(r / m); c = (hi != 0); lat = 1 + W; end
      default: ;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic ci,
                        output logic [W-1:0] olo, output logic [W-1:0] ohi,
                        output logic oc, output logic oz, output int olat);
    logic [W-1:0] elo, ehi;
    logic         ec, eupd;
    int           elat;
    model(o, aa, bb, ci, m_carry, elo, ehi, ec, elat, eupd);
    @(negedge clk);
    check({tag, " ready"}, 32'(in_ready), 32'(1));
    in_valid = 1'b1; op = o; a = aa; b = bb; cin = ci;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    olat = 1;
    while (!out_valid && olat < 40) begin
      @(negedge clk);
      olat++;
    end
    olo = out; ohi = out_hi; oc = cout; oz = zero;
    check({tag, " latency"}, 32'(olat), 32'(elat));
    check({tag, " out"}, 32'(out), 32'(elo));
    check({tag, " out_hi"}, 32'(out_hi), 32'(ehi));
    check({tag, " cout"}, 32'(cout), 32'(ec));
    check({tag, " zero"}, 32'(zero), 32'(elo == '0));
    if (eupd) m_carry = ec;
    @(negedge clk);
    check({tag, " pulse"}, 32'(out_valid), 32'(0));
    check({tag, " hold"}, 32'(out), 32'(elo));
  endtask

  initial begin
    logic [W-1:0] rlo, rhi, exp2;
    logic         rc, rz, seen;
    int           rlat;
    logic [3:0]   ro;
    logic [W-1:0] ra, rb;
    logic         rci;

    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst out", 32'(out), 32'(0));
    check("rst out_hi", 32'(out_hi), 32'(0));
    check("rst cout", 32'(cout), 32'(0));
    check("rst zero", 32'(zero), 32'(0));
    check("rst out_valid", 32'(out_valid), 32'(0));
    check("rst busy", 32'(busy), 32'(0));
    check("rst in_ready", 32'(in_ready), 32'(1));
    rst_n = 1'b1;

    run_op("add", 4'd0, 8'hF0, 8'h20, 1'b0, rlo, rhi, rc, rz, rlat);
    check("add out const", 32'(rlo), 32'h10);
    check("add cout const", 32'(rc), 32'(1));
    check("add zero const", 32'(rz), 32'(0));

    // Back-to-back ADD then ADDC, one result per cycle.
`ifdef ALU_SEQ_CARRY_REG_EN
    exp2 = 8'h01;
`else
    exp2 = 8'h00;
`endif
    @(negedge clk);
    check("b2b ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1; op = 4'd0; a = 8'hFF; b = 8'h01; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("b2b1 valid", 32'(out_valid), 32'(1));
    check("b2b1 out", 32'(out), 32'h00);
    check("b2b1 cout", 32'(cout), 32'(1));
    check("b2b1 ready", 32'(in_ready), 32'(1));
    op = 4'd1; a = 8'h00; b = 8'h00; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b2 valid", 32'(out_valid), 32'(1));
    check("b2b2 out", 32'(out), 32'(exp2));
    check("b2b2 cout", 32'(cout), 32'(0));
    m_carry = 1'b0;

    run_op("sra", 4'd4, 8'h90, 8'd3, 1'b0, rlo, rhi, rc, rz, rlat);
    check("sra out const", 32'(rlo), 32'hF2);
    check("sra lat const", 32'(rlat), 32'(4));
    run_op("sll9", 4'd3, 8'hA5, 8'd9, 1'b0, rlo, rhi, rc, rz, rlat);
    check("sll9 out const", 32'(rlo), 32'h00);
    check("sll9 lat const", 32'(rlat), 32'(9));
    run_op("srl0", 4'd8, 8'h5C, 8'd0, 1'b0, rlo, rhi, rc, rz, rlat);
    check("srl0 out const", 32'(rlo), 32'h5C);
    check("srl0 lat const", 32'(rlat), 32'(1));
    run_op("sra8", 4'd4, 8'h81, 8'hC8, 1'b0, rlo, rhi, rc, rz, rlat);
    check("sra8 out const", 32'(rlo), 32'hFF);

    // MUL with a stray request held during busy.
    @(negedge clk);
    check("mul ready", 32'(in_ready), 32'(1));
    in_valid = 1'b1; op = 4'd9; a = 8'hFF; b = 8'hFF; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mul busy", 32'(busy), 32'(1));
    check("mul not ready", 32'(in_ready), 32'(0));
    op = 4'd0; a = 8'h01; b = 8'h01;
    rlat = 1;
    while (!out_valid && rlat < 40) begin
      if (rlat == 4) in_valid = 1'b0;
      @(negedge clk);
      rlat++;
    end
    in_valid = 1'b0;
    check("mul latency", 32'(rlat), 32'(9));
    check("mul out", 32'(out), 32'h01);
    check("mul out_hi", 32'(out_hi), 32'hFE);
    check("mul cout", 32'(cout), 32'(1));
    @(negedge clk);
    check("mul stray ignored", 32'(out_valid), 32'(0));
    check("mul idle", 32'(busy), 32'(0));
    check("mul hold hi", 32'(out_hi), 32'hFE);

    // Reset in the middle of a MUL.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd9; a = 8'hFF; b = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort out_valid", 32'(out_valid), 32'(0));
    check("abort out", 32'(out), 32'(0));
    check("abort out_hi", 32'(out_hi), 32'(0));
    check("abort in_ready", 32'(in_ready), 32'(1));
    check("abort busy", 32'(busy), 32'(0));
    m_carry = 1'b0;
    seen = 1'b0;
    repeat (W + 2) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort no result", 32'(seen), 32'(0));

    run_op("sub35", 4'd2, 8'd3, 8'd5, 1'b0, rlo, rhi, rc, rz, rlat);
    check("sub35 out const", 32'(rlo), 32'hFE);
    check("sub35 cout const", 32'(rc), 32'(0));
    run_op("sub55", 4'd2, 8'd5, 8'd5, 1'b0, rlo, rhi, rc, rz, rlat);
    check("sub55 zero const", 32'(rz), 32'(1));
    check("sub55 cout const", 32'(rc), 32'(1));
    run_op("opF", 4'hF, 8'h37, 8'h11, 1'b1, rlo, rhi, rc, rz, rlat);
    check("opF out const", 32'(rlo), 32'h00);
    check("opF cout const", 32'(rc), 32'(0));

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) ro = 4'($urandom_range(10, 15));
      else ro = 4'($urandom_range(0, 9));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rci = 1'($urandom);
      if ((ro == 4'd3 || ro == 4'd4 || ro == 4'd8) && $urandom_range(0, 1) == 1)
        rb = 8'($urandom_range(0, 10));
      run_op("rand", ro, ra, rb, rci, rlo, rhi, rc, rz, rlat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
